// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer sharing the EX-stage ALU
// Shift-add multiply and restoring divide, one ALU add/sub per ITER cycle.
module muldiv_sequencer #(
  parameter int         XLEN        = 32,
  parameter logic [3:0] ALU_ADD_SEL = 4'b0000,
  parameter logic [3:0] ALU_SUB_SEL = 4'b0001
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            alu_own,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_sel,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cf,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] ALL1 = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, hi_q, lo_q, result_q;
  logic [4:0]      cnt_q;
  logic            neg_q, done_q;

  logic            is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf, take;
  logic [XLEN-1:0] a_mag, b_mag, hi_d, lo_d, fix_res, div_sel;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    is_div   = op_q[2];
    a_signed = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01 || op_q[1:0] == 2'b10);
    b_signed = is_div ? ~op_q[0] : (op_q[1:0] == 2'b01);
    sa       = a_signed & a_q[XLEN-1];
    sb       = b_signed & b_q[XLEN-1];
    a_mag    = sa ? (~a_q + 1'b1) : a_q;
    b_mag    = sb ? (~b_q + 1'b1) : b_q;
    div_zero = is_div && (b_q == '0);
    div_ovf  = is_div && !op_q[0] && (a_q == SMIN) && (b_q == ALL1);

    // Divide step: partial remainder {hi, lo[msb]} is 33 bits; hi[msb] is its overflow bit.
    take = hi_q[XLEN-1] | alu_cf;
    hi_d = hi_q;
    lo_d = lo_q;
    if (is_div) begin
      hi_d = take ? alu_r : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
      lo_d = {lo_q[XLEN-2:0], take};
    end else if (lo_q[0]) begin
      {hi_d, lo_d} = {alu_cf, alu_r, lo_q[XLEN-1:1]};
    end else begin
      {hi_d, lo_d} = {1'b0, hi_q, lo_q[XLEN-1:1]};
    end

    prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
    div_sel  = op_q[1] ? hi_q : lo_q;
    if (is_div) fix_res = neg_q ? (~div_sel + 1'b1) : div_sel;
    else        fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (kill && state_q != S_IDLE) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: if (start && !kill) begin
            op_q    <= op;
            a_q     <= a;
            b_q     <= b;
            state_q <= S_PREP;
          end
          S_PREP: begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= a_mag;
            b_q   <= b_mag;
            neg_q <= (is_div && op_q[1]) ? sa : (sa ^ sb);
            if (div_zero) begin
              result_q <= op_q[1] ? a_q : ALL1;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (div_ovf) begin
              result_q <= op_q[1] ? '0 : SMIN;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_ITER;
            end
          end
          S_ITER: begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) state_q <= S_FIX;
          end
          S_FIX: begin
            result_q <= fix_res;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign alu_own = (state_q == S_ITER);
  assign alu_a   = !alu_own ? '0 : (is_div ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : hi_q);
  assign alu_b   = alu_own ? b_q : '0;
  assign alu_sel = (alu_own && is_div) ? ALU_SUB_SEL : ALU_ADD_SEL;
  assign stall   = (state_q == S_IDLE) ? start : (state_q != S_DONE);
  assign done    = done_q;
  assign result  = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
// Arithmetic reference model plus per-cycle timing/output checks.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        kill = 1'b0;
  logic        alu_own;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_sel;
  logic        alu_cf;
  logic        stall, done;
  logic [31:0] result;
  logic [32:0] alu_sum;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int aown_cnt = 0;
  logic        mon_en = 1'b0;
  logic        busy = 1'b0;
  logic        short_op = 1'b0;
  logic [31:0] exp_res = 32'd0;
  logic [31:0] hold = 32'd0;

  muldiv_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .kill(kill),
    .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_r(alu_r), .alu_cf(alu_cf), .stall(stall), .done(done), .result(result)
  );

  // Shared EX-stage ALU
  assign alu_sum = (alu_sel == 4'b0001) ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1)
                                        : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_r  = alu_sum[31:0];
  assign alu_cf = alu_sum[32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    int xi, yi;
    logic [31:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    xi = x;
    yi = y;
    r = 32'd0;
    case (o)
      3'd0: begin p = ux * uy; r = p[31:0];  end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * uy; r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: if (y == 0) r = 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = xi / yi;
      3'd5: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: if (y == 0) r = x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = 32'd0;
            else r = xi % yi;
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic logic is_short(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  // Per-cycle compare: done at T+35 (T+2 for corner cases), alu_own for the 32 ITER cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy) begin
        int k, dk;
        k  = cyc - t0;
        dk = short_op ? 1 : 34;
        if (alu_own) aown_cnt++;
        chk("done_timing", {31'd0, done}, {31'd0, k == dk});
        chk("alu_own_window", {31'd0, alu_own}, {31'd0, !short_op && k >= 1 && k <= 32});
        chk("stall_busy", {31'd0, stall}, {31'd0, k < dk});
        if (k >= dk) begin
          chk("result_model", result, exp_res);
          hold = exp_res;
          busy = 1'b0;
        end else begin
          chk("result_hold_busy", result, hold);
        end
      end else begin
        chk("done_idle", {31'd0, done}, 32'd0);
        chk("alu_own_idle", {31'd0, alu_own}, 32'd0);
        chk("stall_idle", {31'd0, stall}, {31'd0, start});
        chk("result_hold", result, hold);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    #1 chk("stall_on_start", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    t0 = cyc;
    exp_res = model(o, x, y);
    short_op = is_short(o, x, y);
    aown_cnt = 0;
    busy = 1'b1;
  endtask

  task automatic wait_done(input string nm, input logic [31:0] lit);
    int n;
    n = 0;
    while (busy && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (busy) begin
      chk({nm, "_timeout"}, 32'd1, 32'd0);
      busy = 1'b0;
    end
    chk(nm, result, lit);
    chk({nm, "_alu_own_cycles"}, aown_cnt, short_op ? 32'd0 : 32'd32);
  endtask

  task automatic run(input string nm, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] lit);
    issue(o, x, y);
    wait_done(nm, lit);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_result", result, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_alu_own", {31'd0, alu_own}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    run("mul_7x6",        3'd0, 32'd7,          32'd6,          32'd42);
    run("mul_neg",        3'd0, 32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1);
    run("mulh_m2x3",      3'd1, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF);
    run("mulh_min_min",   3'd1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000);
    run("mulhu_max",      3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE);
    run("mulhsu_m1",      3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF);
    run("div_m7_2",       3'd4, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD);
    run("rem_m7_2",       3'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF);
    run("divu_100_7",     3'd5, 32'd100,        32'd7,          32'd14);
    run("remu_100_7",     3'd7, 32'd100,        32'd7,          32'd2);
    run("divu_big",       3'd5, 32'hFFFF_FFFF,  32'h8000_0001,  32'd1);
    run("divu_by0",       3'd5, 32'd13,         32'd0,          32'hFFFF_FFFF);
    run("remu_by0",       3'd7, 32'd13,         32'd0,          32'd13);
    run("rem_by0_signed", 3'd6, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9);
    run("div_ovf",        3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000);
    run("rem_ovf",        3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0);

    // Kill during the 10th ITER cycle: no done, result unchanged.
    issue(3'd0, 32'd9, 32'd9);
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    busy = 1'b0;
    chk("kill_idle_alu_own", {31'd0, alu_own}, 32'd0);
    chk("kill_idle_stall", {31'd0, stall}, 32'd0);
    chk("kill_result_kept", result, 32'd0);
    repeat (30) @(posedge clk);
    run("mul_after_kill", 3'd0, 32'd3, 32'd5, 32'd15);

    // Kill together with start in IDLE: not accepted.
    @(posedge clk); #1;
    op = 3'd0; a = 32'd2; b = 32'd2; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("kill_start_not_taken", {31'd0, stall | alu_own}, 32'd0);

    // Reset during ITER.
    issue(3'd5, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    busy = 1'b0;
    hold = 32'd0;
    chk_reset_outputs();
    rst = 1'b1;
    run("divu_after_rst", 3'd5, 32'd1000, 32'd3, 32'd333);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
